mac16_share_sched: RTL and testbench
====================================

Name: mac16_share_sched

Overview:
- Round-robin scheduler that shares one signed 16x16 SB_MAC16 multiplier (configured as a combinational or pipelined signed multiply) between NUM_REQ requesters.
- Each requester submits an operand pair with a valid/ready handshake and an opcode: plain multiply, multiply-accumulate, or load accumulator.
- Products or accumulator values return on a shared result bus, tagged with the requester id.
- Sits between the window/FFT/magnitude stages of the waterfall pipeline and the single hardware multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 0, clock edges between mul_a/mul_b changing and mul_o valid; 0 = combinational MAC16, 1 or 2 = pipeline registers enabled (legal range 0..2).
- ID_W, 2, requester id width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  grant enable; 0 blocks new grants, in-flight ops still complete.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  in  NUM_REQ*16  signed operand A, requester i at bits [16i+15:16i].
- req_b  in  NUM_REQ*16  signed operand B, same packing as req_a.
- req_op  in  NUM_REQ*2  opcode: 00 MUL, 01 MAC (acc+=p), 10 LOAD (acc=p), 11 reserved, treated as MUL.
- mul_a  out  16  to MAC16 A, registered.
- mul_b  out  16  to MAC16 B, registered.
- mul_o  in  32  signed product from MAC16.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  ID_W  requester index of the result.
- res_p  out  32  signed result.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (async, active-high):
  - Outputs: req_ready=0, mul_a=0, mul_b=0, res_valid=0, res_id=0, res_p=0, busy=0.
  - All accumulators cleared to 0; in-flight pipeline flushed with no res_valid afterwards; round-robin pointer set so requester 0 has top priority.
- Arbitration:
  - req_ready is combinational from req_valid, en and the pointer.
  - When en=1, grant the first requester with req_valid=1, searching cyclically from index (last_grant+1); all other ready bits are 0.
  - At most one grant per cycle; one new op may be accepted every cycle (full throughput).
  - A handshake is valid && ready at a rising edge.
  - On handshake: the pointer moves to the granted index; mul_a/mul_b load that requester's operands; id and op enter a tag shift pipeline of depth MUL_LATENCY+1.
  - Requesters must hold valid and data stable until ready. The block never drops an accepted op.
- Latency:
  - Handshake at edge t: mul_o is valid after edge t+MUL_LATENCY and is sampled at edge t+MUL_LATENCY+1.
  - res_valid is high during the cycle following that edge, i.e. MUL_LATENCY+1 edges after the handshake, for exactly one cycle per accepted op.
  - Results return in acceptance order.
- Result arithmetic (p = mul_o, 32-bit signed):
  - MUL: res_p=p; acc unchanged.
  - MAC: acc[id]=acc[id]+p, wrapping modulo 2^32, no saturation; res_p = new acc value.
  - LOAD: acc[id]=p; res_p=p.
  - Back-to-back MACs from the same id must chain correctly; the acc update happens at the sampling edge, so there is no hazard.
- Idle and busy:
  - With no handshake, mul_a/mul_b hold their values.
  - busy=1 while any tag pipeline stage is valid.
- Result bus: res_valid has no backpressure; the consumer must take every strobe.
- en=0 mid-stream: req_ready goes 0 the same cycle; the pipeline drains normally.
- Reset mid-operation: immediate flush; results of ops accepted before reset are never emitted.

Test Plan:
- Single requester 0, MUL, a=-2000, b=-1000, MUL_LATENCY=0 -> res_valid one cycle, 1 edge after handshake; res_id=0, res_p=2000000.
- Requesters 0..3 all valid continuously with MUL -> grants 0,1,2,3,0,... one per cycle; results in the same id order with no gaps.
- Requester 2 performs LOAD 100*100, then MAC 300*-200, then MAC -1500*500 -> res_p = 10000, -50000, -800000.
- MAC wrap: LOAD 32767*32767, then four MAC -32768*-32768 -> res_p wraps modulo 2^32 to 1073676289+4*1073741824 mod 2^32 = 1073676289.
- MUL_LATENCY=2, requester 1 op 3*4 -> res_valid 3 edges after handshake with res_p=12; busy high for those 3 cycles.
- Assert reset while 2 ops are in flight -> no res_valid afterwards; accumulators read 0 via a subsequent MAC 1*1 giving res_p=1; requester 0 wins the first grant after reset.

Source files
------------

// File: rtl/mac16_share_sched_if.sv
// Requester, multiplier and result signals of the shared MAC16 scheduler.
// The slave modport is the scheduler side.
interface mac16_share_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic                   en;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*16-1:0]  req_a;
    logic [NUM_REQ*16-1:0]  req_b;
    logic [NUM_REQ*2-1:0]   req_op;
    logic [15:0]            mul_a;
    logic [15:0]            mul_b;
    logic [31:0]            mul_o;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [31:0]            res_p;
    logic                   busy;

    modport slave (
        input  en, req_valid, req_a, req_b, req_op, mul_o,
        output req_ready, mul_a, mul_b, res_valid, res_id, res_p, busy
    );

    modport master (
        output en, req_valid, req_a, req_b, req_op, mul_o,
        input  req_ready, mul_a, mul_b, res_valid, res_id, res_p, busy
    );
endinterface

// File: rtl/mac16_share_sched.sv
// Round-robin scheduler sharing one signed 16x16 MAC16 multiplier
// between NUM_REQ requesters, with per-requester accumulators.
module mac16_share_sched #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 0,
    parameter int ID_W        = 2
) (
    input logic clk,
    input logic reset,
    mac16_share_sched_if.slave bus
);
    localparam int D = MUL_LATENCY + 1;

    logic [ID_W-1:0]    ptr_q;
    logic [15:0]        mul_a_q;
    logic [15:0]        mul_b_q;
    logic               tv_q  [D];
    logic [ID_W-1:0]    tid_q [D];
    logic [1:0]         top_q [D];
    logic [31:0]        acc_q [NUM_REQ];
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [31:0]        res_p_q;

    logic               hs;
    logic [ID_W-1:0]    gnt;
    logic [ID_W-1:0]    idx;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;
    logic [1:0]         sel_op;
    logic [NUM_REQ-1:0] ready;
    logic [31:0]        mac_sum;
    logic               busy_c;

    // Cyclic search starting just after the last granted requester
    always_comb begin
        hs  = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!hs && bus.en && bus.req_valid[idx]) begin
                hs  = 1'b1;
                gnt = idx;
            end
        end
        hs = hs && !reset;
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == ID_W'(i)) begin
                sel_a    = bus.req_a[i*16 +: 16];
                sel_b    = bus.req_b[i*16 +: 16];
                sel_op   = bus.req_op[i*2 +: 2];
                ready[i] = hs;
            end
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int s = 0; s < D; s++) begin
            busy_c = busy_c | tv_q[s];
        end
    end

    assign mac_sum = acc_q[tid_q[D-1]] + bus.mul_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_p_q     <= '0;
            for (int s = 0; s < D; s++) begin
                tv_q[s]  <= 1'b0;
                tid_q[s] <= '0;
                top_q[s] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            tv_q[0]  <= hs;
            tid_q[0] <= gnt;
            top_q[0] <= sel_op;
            for (int s = 1; s < D; s++) begin
                tv_q[s]  <= tv_q[s-1];
                tid_q[s] <= tid_q[s-1];
                top_q[s] <= top_q[s-1];
            end
            if (hs) begin
                ptr_q   <= gnt;
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end
            res_valid_q <= tv_q[D-1];
            // Accumulator updates at the sampling edge, so chained MACs see it
            if (tv_q[D-1]) begin
                res_id_q <= tid_q[D-1];
                unique case (top_q[D-1])
                    2'b01: begin
                        acc_q[tid_q[D-1]] <= mac_sum;
                        res_p_q           <= mac_sum;
                    end
                    2'b10: begin
                        acc_q[tid_q[D-1]] <= bus.mul_o;
                        res_p_q           <= bus.mul_o;
                    end
                    default: res_p_q <= bus.mul_o;
                endcase
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_p     = res_p_q;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_mac16_share_sched.sv
// Bench for mac16_share_sched: a latency-0 and a latency-2 instance run
// the same request stream against a queue-based model of the scheduler.
module tb_mac16_share_sched;
    localparam int N = 4;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [1:0]         op;
    } op_t;

    typedef struct {
        int                 due;
        int                 id;
        logic signed [31:0] p;
    } exp_t;

    typedef struct {
        int id;
        int p;
        int cyc;
    } log_t;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic [N-1:0]    rv;
    logic [N*16-1:0] ra;
    logic [N*16-1:0] rb;
    logic [N*2-1:0]  rop;

    int checks   = 0;
    int failures = 0;

    op_t  rq [N][$];
    exp_t qs [2][$];
    log_t lg [2][$];
    int   cyc = 0;
    int   ptr = N - 1;
    int   last_hs = 0;
    logic signed [31:0] acc [N];
    logic [15:0] ema = '0;
    logic [15:0] emb = '0;

    always #5 clk = ~clk;

    mac16_share_sched_if #(.NUM_REQ(N), .ID_W(2)) b0 ();
    mac16_share_sched_if #(.NUM_REQ(N), .ID_W(2)) b2 ();

    mac16_share_sched #(.NUM_REQ(N), .MUL_LATENCY(0), .ID_W(2)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );
    mac16_share_sched #(.NUM_REQ(N), .MUL_LATENCY(2), .ID_W(2)) u2 (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );

    assign b0.en = en;  assign b0.req_valid = rv;
    assign b0.req_a = ra; assign b0.req_b = rb; assign b0.req_op = rop;
    assign b2.en = en;  assign b2.req_valid = rv;
    assign b2.req_a = ra; assign b2.req_b = rb; assign b2.req_op = rop;

    // MAC16 models: combinational, and two pipeline registers
    logic signed [31:0] m1, m2;
    assign b0.mul_o = $signed(b0.mul_a) * $signed(b0.mul_b);
    always @(posedge clk) begin
        m1 <= $signed(b2.mul_a) * $signed(b2.mul_b);
        m2 <= m1;
    end
    assign b2.mul_o = m2;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (reset || !en) return -1;
        for (int k = 1; k <= N; k++) begin
            if (rv[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            rv[i] = rq[i].size() > 0;
            if (rq[i].size() > 0) begin
                ra[i*16 +: 16] = rq[i][0].a;
                rb[i*16 +: 16] = rq[i][0].b;
                rop[i*2 +: 2]  = rq[i][0].op;
            end
        end
    endfunction

    // Model: grant, operand latch, accumulator and due-cycle of each result
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qs[0].delete();
            qs[1].delete();
            ptr = N - 1;
            for (int i = 0; i < N; i++) acc[i] = 0;
            ema = '0;
            emb = '0;
        end else begin
            int g;
            op_t o;
            logic signed [31:0] pr, r;
            cyc++;
            g = model_grant();
            if (g >= 0) begin
                o  = rq[g].pop_front();
                pr = $signed(o.a) * $signed(o.b);
                case (o.op)
                    2'b01:   begin acc[g] = acc[g] + pr; r = acc[g]; end
                    2'b10:   begin acc[g] = pr; r = pr; end
                    default: r = pr;
                endcase
                qs[0].push_back('{cyc + 1, g, r});
                qs[1].push_back('{cyc + 3, g, r});
                ptr = g;
                ema = o.a;
                emb = o.b;
                last_hs = cyc;
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        drive();
    end

    task automatic cmp(input int d, input logic v, input logic [1:0] id,
                       input logic [31:0] p, input logic bsy,
                       input logic [3:0] rdy, input logic [15:0] ma,
                       input logic [15:0] mb);
        logic ev;
        int g;
        logic [3:0] erdy;
        g    = model_grant();
        erdy = (g >= 0) ? 4'(1 << g) : 4'd0;
        ev   = qs[d].size() > 0 && qs[d][0].due == cyc;
        chk($sformatf("res_valid[%0d]", d), 64'(v), 64'(ev));
        if (ev) begin
            chk($sformatf("res_id[%0d]", d), 64'(id), 64'(qs[d][0].id));
            chk($sformatf("res_p[%0d]", d), 64'($signed(p)), 64'(qs[d][0].p));
            void'(qs[d].pop_front());
        end
        chk($sformatf("busy[%0d]", d), 64'(bsy), 64'(qs[d].size() > 0));
        chk($sformatf("req_ready[%0d]", d), 64'(rdy), 64'(erdy));
        chk($sformatf("mul_a[%0d]", d), 64'(ma), 64'(ema));
        chk($sformatf("mul_b[%0d]", d), 64'(mb), 64'(emb));
        if (v) lg[d].push_back('{int'(id), int'($signed(p)), cyc});
    endtask

    always @(negedge clk) begin
        cmp(0, b0.res_valid, b0.res_id, b0.res_p, b0.busy, b0.req_ready,
            b0.mul_a, b0.mul_b);
        cmp(1, b2.res_valid, b2.res_id, b2.res_p, b2.busy, b2.req_ready,
            b2.mul_a, b2.mul_b);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic push(input int r, input int a, input int b, input int op);
        rq[r].push_back('{16'(a), 16'(b), 2'(op)});
        drive();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()
                + qs[0].size() + qs[1].size()) > 0 && n < 200) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", 64'(n < 200), 64'(1));
        tick(2);
    endtask

    initial begin
        int s0, s1, bc;
        reset = 1'b1;
        en    = 1'b1;
        rv    = '0;
        ra    = '0;
        rb    = '0;
        rop   = '0;
        tick(2);
        chk("rst_res_p0", 64'(b0.res_p), 64'(0));
        chk("rst_res_id2", 64'(b2.res_id), 64'(0));
        reset = 1'b0;

        // All four requesters valid: grants rotate 0,1,2,3 with no gaps
        s0 = lg[0].size();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, i + 1, 10 * (i + 1), 0);
        wait_idle();
        chk("rr_count", 64'(lg[0].size() - s0), 64'(8));
        for (int k = 0; k < 8 && s0 + k < lg[0].size(); k++) begin
            chk("rr_id", 64'(lg[0][s0+k].id), 64'(k % 4));
            chk("rr_p", 64'(lg[0][s0+k].p), 64'(10 * ((k%4)+1) * ((k%4)+1)));
            if (k > 0)
                chk("rr_gap", 64'(lg[0][s0+k].cyc - lg[0][s0+k-1].cyc), 64'(1));
        end

        // en low blocks grants
        en = 1'b0;
        push(3, 2, 2, 0);
        s0 = lg[0].size();
        tick(4);
        chk("en0_ready", 64'(b0.req_ready), 64'(0));
        chk("en0_nores", 64'(lg[0].size() - s0), 64'(0));
        en = 1'b1;
        wait_idle();
        chk("en1_p", 64'(lg[0][lg[0].size()-1].p), 64'(4));

        // Single MUL on requester 0
        push(0, -2000, -1000, 0);
        wait_idle();
        chk("mul_id", 64'(lg[0][lg[0].size()-1].id), 64'(0));
        chk("mul_p", 64'(lg[0][lg[0].size()-1].p), 64'(2000000));

        // LOAD then chained MACs on requester 2
        s0 = lg[0].size();
        s1 = lg[1].size();
        push(2, 100, 100, 2);
        push(2, 300, -200, 1);
        push(2, -1500, 500, 1);
        wait_idle();
        chk("mac_p0", 64'(lg[0][s0].p), 64'(10000));
        chk("mac_p1", 64'(lg[0][s0+1].p), 64'(-50000));
        chk("mac_p2", 64'(lg[0][s0+2].p), 64'(-800000));
        chk("mac_l2_p2", 64'(lg[1][s1+2].p), 64'(-800000));

        // Accumulator wraps modulo 2^32
        push(1, 32767, 32767, 2);
        for (int k = 0; k < 4; k++) push(1, -32768, -32768, 1);
        wait_idle();
        chk("wrap_p", 64'(lg[0][lg[0].size()-1].p), 64'(1073676289));
        chk("wrap_l2_p", 64'(lg[1][lg[1].size()-1].p), 64'(1073676289));

        // Latency-2 timing and busy window
        bc = 0;
        push(1, 3, 4, 3);
        repeat (8) begin
            @(negedge clk);
            if (b2.busy) bc++;
        end
        wait_idle();
        chk("l2_busy_cycles", 64'(bc), 64'(3));
        chk("l2_p", 64'(lg[1][lg[1].size()-1].p), 64'(12));
        chk("l2_latency", 64'(lg[1][lg[1].size()-1].cyc - last_hs), 64'(3));

        // Reset with two ops in flight
        push(0, 5, 6, 0);
        push(1, 7, 8, 1);
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_res_p2", 64'(b2.res_p), 64'(0));
        chk("rstmid_busy2", 64'(b2.busy), 64'(0));
        chk("rstmid_mul_a2", 64'(b2.mul_a), 64'(0));
        tick(1);
        reset = 1'b0;
        s0 = lg[0].size();
        s1 = lg[1].size();
        tick(5);
        chk("rstmid_nores", 64'(lg[1].size() - s1), 64'(0));
        push(1, 1, 1, 1);
        push(0, 9, 9, 0);
        wait_idle();
        chk("post_rst_first_id", 64'(lg[1][s1].id), 64'(0));
        chk("post_rst_first_p", 64'(lg[1][s1].p), 64'(81));
        chk("post_rst_mac_p", 64'(lg[1][s1+1].p), 64'(1));
        chk("post_rst_mac_p0", 64'(lg[0][s0+1].p), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
